// File: rtl/acc_cell_if.sv
// acc_cell_if: product stream in, ready/valid result out, plus window control.
interface acc_cell_if #(
    parameter int WORD_WDT = 16,
    parameter int LEN_WDT  = 8
);
    logic                clk_en;
    logic                acc_clr;
    logic [LEN_WDT-1:0]  acc_len;
    logic [WORD_WDT-1:0] acc_op;
    logic                acc_op_val;
    logic [WORD_WDT-1:0] acc_res;
    logic                acc_res_val;
    logic                acc_res_rdy;
    logic                acc_ovf_err;

    modport slave (
        input  clk_en, acc_clr, acc_len, acc_op, acc_op_val, acc_res_rdy,
        output acc_res, acc_res_val, acc_ovf_err
    );

    modport master (
        output clk_en, acc_clr, acc_len, acc_op, acc_op_val, acc_res_rdy,
        input  acc_res, acc_res_val, acc_ovf_err
    );
endinterface

// File: rtl/acc_cell.sv
// acc_cell: sums acc_len consecutive valid products (saturating or wrapping) into one held result.
module acc_cell #(
    parameter int ACC_WORD_WDT = 16,
    parameter int ACC_FRAC_WDT = 8,
    parameter int ACC_SATUR    = 1,
    parameter int ACC_LEN_WDT  = 8
) (
    input  logic      clk,
    input  logic      rst,
    acc_cell_if.slave bus
);
    localparam int W = ACC_WORD_WDT;
    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {IDLE, ACC} state_t;

    state_t                 state_q;
    logic [ACC_LEN_WDT-1:0] cnt_q, len_q, len_d;
    logic [W-1:0]           acc_q, res_q, sum_d;
    logic [W:0]             sum_ext;
    logic                   res_val_q, ovf_q;
    logic                   last, done, pop;

    always_comb begin
        assert (ACC_FRAC_WDT < ACC_WORD_WDT);
        sum_ext = {acc_q[W-1], acc_q} + {bus.acc_op[W-1], bus.acc_op};
        sum_d   = (ACC_SATUR != 0 && sum_ext[W] != sum_ext[W-1]) ? (sum_ext[W] ? MIN_V : MAX_V)
                                                                 : sum_ext[W-1:0];
        len_d   = (state_q != IDLE) ? len_q
                : (bus.acc_len == '0) ? ACC_LEN_WDT'(1) : bus.acc_len;
        last    = cnt_q == len_d - ACC_LEN_WDT'(1);
        done    = bus.acc_op_val && last;
        pop     = res_val_q && bus.acc_res_rdy;
    end

    // A completing window overrides the pop; a full, unread register drops it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= ACC_LEN_WDT'(1);
            acc_q     <= '0;
            res_q     <= '0;
            res_val_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (bus.clk_en) begin
            if (bus.acc_clr) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                acc_q     <= '0;
                res_val_q <= 1'b0;
                ovf_q     <= 1'b0;
            end else begin
                if (bus.acc_op_val) begin
                    len_q   <= len_d;
                    state_q <= last ? IDLE : ACC;
                    cnt_q   <= last ? '0 : cnt_q + ACC_LEN_WDT'(1);
                    acc_q   <= last ? '0 : sum_d;
                end
                if (done && res_val_q && !bus.acc_res_rdy) begin
                    ovf_q <= 1'b1;
                end else if (done) begin
                    res_q     <= sum_d;
                    res_val_q <= 1'b1;
                end else if (pop) begin
                    res_val_q <= 1'b0;
                end
            end
        end
    end

    assign bus.acc_res     = res_q;
    assign bus.acc_res_val = res_val_q;
    assign bus.acc_ovf_err = ovf_q;
endmodule

// File: tb/tb_acc_cell.sv
// tb_acc_cell: drives a saturating and a wrapping acc_cell in lockstep against a scoreboard model.
module tb_acc_cell;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1, clr = 1'b0, val = 1'b0, rdy = 1'b1;
    logic [7:0]  len = 8'd1;
    logic [15:0] op = '0;

    always #5 clk = ~clk;

    acc_cell_if #(.WORD_WDT(16), .LEN_WDT(8)) ifs ();
    acc_cell_if #(.WORD_WDT(16), .LEN_WDT(8)) ifw ();

    assign ifs.clk_en = en;  assign ifw.clk_en = en;
    assign ifs.acc_clr = clr; assign ifw.acc_clr = clr;
    assign ifs.acc_len = len; assign ifw.acc_len = len;
    assign ifs.acc_op = op;   assign ifw.acc_op = op;
    assign ifs.acc_op_val = val;  assign ifw.acc_op_val = val;
    assign ifs.acc_res_rdy = rdy; assign ifw.acc_res_rdy = rdy;

    acc_cell #(.ACC_SATUR(1)) dut_s (.clk(clk), .rst(rst), .bus(ifs.slave));
    acc_cell #(.ACC_SATUR(0)) dut_w (.clk(clk), .rst(rst), .bus(ifw.slave));

    int checks = 0, errors = 0;
    logic [15:0] q_s[$], q_w[$], log_s[$], log_w[$];
    int m_acc_s, m_acc_w, m_cnt, m_len, r_s, r_w;
    bit m_val, m_ovf, m_done;

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int add(int a, int b, bit sat);
        int s = a + b;
        if (sat) return (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
        return ((s + 32768) & 65535) - 32768;
    endfunction

    // Reference model: window sums as integers, output register as a flag plus expected queue.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc_s = 0; m_acc_w = 0; m_cnt = 0; m_len = 1; m_val = 0; m_ovf = 0;
            q_s.delete(); q_w.delete();
        end else if (en) begin
            if (clr) begin
                m_acc_s = 0; m_acc_w = 0; m_cnt = 0; m_val = 0; m_ovf = 0;
                q_s.delete(); q_w.delete();
            end else begin
                m_done = 0;
                if (val) begin
                    if (m_cnt == 0) m_len = (len == 0) ? 1 : int'(len);
                    m_acc_s = add(m_acc_s, int'($signed(op)), 1);
                    m_acc_w = add(m_acc_w, int'($signed(op)), 0);
                    m_cnt++;
                    if (m_cnt == m_len) begin
                        m_done = 1; r_s = m_acc_s; r_w = m_acc_w;
                        m_acc_s = 0; m_acc_w = 0; m_cnt = 0;
                    end
                end
                if (m_done && m_val && !rdy) m_ovf = 1;
                else if (m_done) begin
                    m_val = 1;
                    q_s.push_back(16'(r_s));
                    q_w.push_back(16'(r_w));
                end else if (m_val && rdy) m_val = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("val_s", 16'(ifs.acc_res_val), 16'(m_val));
            chk("val_w", 16'(ifw.acc_res_val), 16'(m_val));
            chk("ovf_s", 16'(ifs.acc_ovf_err), 16'(m_ovf));
            chk("ovf_w", 16'(ifw.acc_ovf_err), 16'(m_ovf));
            if (m_val) begin
                if (q_s.size() == 0 || q_w.size() == 0) begin
                    chk("sb_empty", 16'(q_s.size() + q_w.size()), 16'd2);
                end else begin
                    chk("res_s", ifs.acc_res, q_s[0]);
                    chk("res_w", ifw.acc_res, q_w[0]);
                    if (en && rdy && !clr) begin
                        void'(q_s.pop_front());
                        void'(q_w.pop_front());
                        log_s.push_back(ifs.acc_res);
                        log_w.push_back(ifw.acc_res);
                    end
                end
            end
        end
    end

    task automatic cyc(bit e, bit c, logic [7:0] l, logic [15:0] o, bit v, bit r);
        @(posedge clk);
        #2;
        en = e; clr = c; len = l; op = o; val = v; rdy = r;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1, 0, len, 16'h0, 0, 1);
    endtask

    task automatic logchk(string name, int idx, logic [15:0] es, logic [15:0] ew);
        if (idx >= log_s.size()) chk({name, "_missing"}, 16'(log_s.size()), 16'(idx + 1));
        else begin
            chk({name, "_s"}, log_s[idx], es);
            chk({name, "_w"}, log_w[idx], ew);
        end
    endtask

    initial begin
        #12;
        chk("rst_res_s", ifs.acc_res, 16'h0);
        chk("rst_val_s", 16'(ifs.acc_res_val), 16'h0);
        chk("rst_ovf_s", 16'(ifs.acc_ovf_err), 16'h0);
        chk("rst_res_w", ifw.acc_res, 16'h0);
        @(posedge clk); #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1, 0, 4, 16'h0100, 1, 1);
        idle(2);
        cyc(1, 0, 2, 16'h7000, 1, 1); cyc(1, 0, 2, 16'h2000, 1, 1);
        cyc(1, 0, 2, 16'h8100, 1, 1); cyc(1, 0, 2, 16'h8100, 1, 1);
        idle(2);
        for (int i = 0; i < 8; i++) cyc(1, 0, 1, 16'hF000 + 16'(i) * 16'h0123, 1, 1);
        idle(2);
        for (int i = 1; i <= 4; i++) cyc(1, 0, 2, 16'(i) * 16'h0100, 1, 0);
        cyc(1, 0, 2, 16'h0, 0, 0);
        @(negedge clk);
        chk("ovf_set", 16'(ifs.acc_ovf_err), 16'h1);
        chk("ovf_held", ifs.acc_res, 16'h0300);
        cyc(1, 0, 2, 16'h0, 0, 1);
        cyc(1, 0, 2, 16'h0, 0, 1);
        @(negedge clk);
        chk("ovf_sticky", 16'(ifs.acc_ovf_err), 16'h1);
        chk("val_fell", 16'(ifs.acc_res_val), 16'h0);
        cyc(1, 1, 2, 16'h0, 0, 1);
        cyc(1, 0, 2, 16'h0, 0, 1);
        @(negedge clk);
        chk("ovf_clr", 16'(ifs.acc_ovf_err), 16'h0);
        cyc(1, 0, 4, 16'h0100, 1, 1); cyc(1, 0, 4, 16'h0100, 1, 1);
        @(posedge clk); #2 rst = 1'b1; val = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1, 0, 4, 16'h0100, 1, 1);
        idle(2);
        cyc(1, 0, 4, 16'h0100, 1, 1); cyc(1, 0, 4, 16'h0100, 1, 1);
        cyc(1, 1, 4, 16'h0500, 1, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 4, 16'h0100, 1, 1);
        idle(2);
        cyc(1, 0, 3, 16'h0100, 1, 1);
        cyc(1, 0, 7, 16'h0000, 0, 1);
        cyc(0, 0, 9, 16'h7777, 1, 0);
        cyc(1, 0, 5, 16'h0200, 1, 1);
        cyc(0, 0, 1, 16'h1111, 1, 1);
        cyc(1, 0, 0, 16'h0300, 1, 1);
        idle(3);
        logchk("len4", 0, 16'h0400, 16'h0400);
        logchk("pos", 1, 16'h7FFF, 16'h9000);
        logchk("neg", 2, 16'h8000, 16'h0200);
        for (int i = 0; i < 8; i++) logchk("len1", 3 + i, 16'hF000 + 16'(i) * 16'h0123, 16'hF000 + 16'(i) * 16'h0123);
        logchk("ovf_res", 11, 16'h0300, 16'h0300);
        logchk("after_rst", 12, 16'h0400, 16'h0400);
        logchk("after_clr", 13, 16'h0400, 16'h0400);
        logchk("gaps", 14, 16'h0600, 16'h0600);
        chk("log_count", 16'(log_s.size()), 16'd15);
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, 8'($urandom_range(0, 5)),
                16'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
        idle(4);
        @(negedge clk);
        chk("drained_s", 16'(q_s.size()), 16'h0);
        chk("drained_w", 16'(q_w.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
